vote_demux: RTL and testbench

//   Registered 1-to-N demultiplexer with valid/ready handshake, the routing counterpart of the 2:1 mux.

---
 rtl/vote_demux_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/vote_demux.sv | 102 ++++++++++
 tb/tb_vote_demux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vote_demux_pkg.sv
// Shared definitions for the ballot demux and the result/display logic that reads its tallies.
// State codes and the default tally width live here so both sides agree on them.
package vote_demux_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 8;

  // Bits needed to count LOCKOUT-1 down to zero; at least one.
  function automatic int hold_w(input int lockout);
    return (lockout > 1) ? $clog2(lockout) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-lane saturating tally: holds at all-ones instead of wrapping.
// A clear takes priority over an increment on the same edge.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else if (clr)
      r_q <= '0;
    else if (inc && (r_q != {CNT_W{1'b1}}))
      r_q <= r_q + 1'b1;
  end

  assign q = r_q;

endmodule

// File: rtl/vote_demux.sv
// Registered 1-to-N ballot demux: steers one ballot to a lane strobe, keeps per-lane
// saturating tallies, and refuses new ballots for LOCKOUT cycles after each emit.
module vote_demux
  import vote_demux_pkg::*;
#(
  parameter int N_OUT   = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LOCKOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bit,
  input  logic                   tally_clr,
  output logic [N_OUT-1:0]       out_valid,
  output logic [N_OUT-1:0]       out_bit,
  output logic [N_OUT*CNT_W-1:0] tally,
  output logic                   sel_err,
  output logic                   busy
);

  localparam int              HW        = hold_w(LOCKOUT);
  localparam int              HOLD_INIT = (LOCKOUT > 0) ? LOCKOUT - 1 : 0;
  localparam logic [HW-1:0]   HOLD_LD   = HW'(HOLD_INIT);
  localparam logic [SEL_W:0]  N_OUT_L   = (SEL_W+1)'(N_OUT);

  state_t             r_state, w_next;
  logic [HW-1:0]      r_hold;
  logic [N_OUT-1:0]   r_out_valid, r_out_bit;
  logic               r_sel_err;
  logic [N_OUT-1:0]   w_hit;
  logic               w_sel_ok, w_accept;

  assign w_sel_ok = ({1'b0, in_sel} < N_OUT_L);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_EMIT;
      end
      S_EMIT: begin
        busy   = 1'b1;
        w_next = (LOCKOUT == 0) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (r_hold == '0) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lane outputs are registered at the accept edge so they appear during EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_out_valid <= '0;
      r_out_bit   <= '0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EMIT)
        r_hold <= HOLD_LD;
      else if (r_state == S_HOLD && r_hold != '0)
        r_hold <= r_hold - 1'b1;
      if (w_accept) begin
        r_out_valid <= w_hit;
        r_out_bit   <= w_hit & {N_OUT{in_bit}};
        r_sel_err   <= ~w_sel_ok;
      end else begin
        r_out_valid <= '0;
        r_out_bit   <= '0;
        r_sel_err   <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    assign w_hit[i] = (in_sel == SEL_W'(i));
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (tally_clr),
      .inc (w_accept & w_hit[i] & in_bit),
      .q   (tally[i*CNT_W +: CNT_W])
    );
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_vote_demux.sv
// Scoreboard bench for vote_demux: three instances (4 lanes/lockout 4, 3 lanes/2-bit tally/
// lockout 1, 4 lanes/lockout 0); stimulus pushes expected strobes, monitors pop and compare.
module tb_vote_demux;

  typedef struct {
    int          cyc;
    logic [3:0]  v;
    logic [3:0]  b;
    logic        err;
    logic [31:0] t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: N_OUT=3, CNT_W=2, LOCKOUT=1
  logic a_valid = 0, a_bit = 0, a_clr = 0;
  logic [1:0] a_sel = '0;
  logic a_ready, a_err, a_busy;
  logic [2:0] a_ov, a_ob;
  logic [5:0] a_tally;
  vote_demux #(.N_OUT(3), .SEL_W(2), .CNT_W(2), .LOCKOUT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_sel(a_sel),
    .in_bit(a_bit), .tally_clr(a_clr), .out_valid(a_ov), .out_bit(a_ob),
    .tally(a_tally), .sel_err(a_err), .busy(a_busy));

  // B: N_OUT=4, CNT_W=8, LOCKOUT=4
  logic b_valid = 0, b_bit = 0, b_clr = 0;
  logic [1:0] b_sel = '0;
  logic b_ready, b_err, b_busy;
  logic [3:0] b_ov, b_ob;
  logic [31:0] b_tally;
  vote_demux #(.N_OUT(4), .SEL_W(2), .CNT_W(8), .LOCKOUT(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_sel(b_sel),
    .in_bit(b_bit), .tally_clr(b_clr), .out_valid(b_ov), .out_bit(b_ob),
    .tally(b_tally), .sel_err(b_err), .busy(b_busy));

  // C: N_OUT=4, CNT_W=8, LOCKOUT=0
  logic c_valid = 0, c_bit = 0, c_clr = 0;
  logic [1:0] c_sel = '0;
  logic c_ready, c_err, c_busy;
  logic [3:0] c_ov, c_ob;
  logic [31:0] c_tally;
  vote_demux #(.N_OUT(4), .SEL_W(2), .CNT_W(8), .LOCKOUT(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_sel(c_sel),
    .in_bit(c_bit), .tally_clr(c_clr), .out_valid(c_ov), .out_bit(c_ob),
    .tally(c_tally), .sel_err(c_err), .busy(c_busy));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic mon(input string name, inout exp_t q[$], input logic [3:0] v,
                     input logic [3:0] b, input logic err, input logic [31:0] t);
    exp_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected strobe @cyc %0d: v=%b b=%b err=%b t=%h", name, cyc, v, b, err, t);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.v !== v || e.b !== b || e.err !== err || e.t !== t) begin
        n_fail++;
        $display("FAIL %s: got cyc=%0d v=%b b=%b err=%b t=%h expected cyc=%0d v=%b b=%b err=%b t=%h",
                 name, cyc, v, b, err, t, e.cyc, e.v, e.b, e.err, e.t);
      end
    end
  endtask

  always @(negedge clk) if (a_ov != '0 || a_err) mon("strobe_a", qa, {1'b0, a_ov}, {1'b0, a_ob}, a_err, {26'b0, a_tally});
  always @(negedge clk) if (b_ov != '0 || b_err) mon("strobe_b", qb, b_ov, b_ob, b_err, b_tally);
  always @(negedge clk) if (c_ov != '0 || c_err) mon("strobe_c", qc, c_ov, c_ob, c_err, c_tally);

  initial begin
    int t0;
    logic [31:0] tc;
    logic [3:0] oh;

    // Reset held two edges
    step(2);
    rst = 0;
    chk("rst_ready", {29'b0, a_ready, b_ready, c_ready}, 32'h7);
    chk("rst_busy", {29'b0, a_busy, b_busy, c_busy}, 32'h0);
    chk("rst_outs", {21'b0, a_ov, b_ov, c_ov, a_err, b_err, c_err}, 32'h0);
    chk("rst_tally_b", b_tally, 32'h0);
    chk("rst_tally_a", {26'b0, a_tally}, 32'h0);

    // Route sel=2 on B, then a ballot offered during lockout
    t0 = cyc;
    b_valid = 1; b_sel = 2; b_bit = 1;
    qb.push_back('{t0 + 1, 4'b0100, 4'b0100, 1'b0, 32'h0001_0000});
    step(1);
    b_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      chk("lock_ready_low", {31'b0, b_ready}, 32'h0);
      if (i == 3) begin b_valid = 1; b_sel = 1; b_bit = 1; end
      if (i == 4) chk("lock_ignored_tally1", {24'b0, b_tally[15:8]}, 32'h0);
      step(1);
    end
    chk("ready_at_T6", {31'b0, b_ready}, 32'h1);
    qb.push_back('{t0 + 7, 4'b0010, 4'b0010, 1'b0, 32'h0001_0100});
    step(1);
    b_valid = 0;
    chk("busy_emit", {31'b0, b_busy}, 32'h1);
    step(5);
    chk("ready_after_2nd", {31'b0, b_ready}, 32'h1);

    // Reset during EMIT
    b_valid = 1; b_sel = 0; b_bit = 1;
    qb.push_back('{cyc + 1, 4'b0001, 4'b0001, 1'b0, 32'h0001_0101});
    step(1);
    b_valid = 0; rst = 1;
    step(1);
    rst = 0;
    chk("rstemit_tally", b_tally, 32'h0);
    chk("rstemit_ready", {30'b0, b_ready, b_busy}, 32'h2);

    // Reset during HOLD, then immediate accept of a zero ballot
    b_valid = 1; b_sel = 3; b_bit = 1;
    qb.push_back('{cyc + 1, 4'b1000, 4'b1000, 1'b0, 32'h0100_0000});
    step(1);
    b_valid = 0;
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    chk("rsthold_ready", {30'b0, b_ready, b_busy}, 32'h2);
    chk("rsthold_tally", b_tally, 32'h0);
    b_valid = 1; b_sel = 1; b_bit = 0;
    qb.push_back('{cyc + 1, 4'b0010, 4'b0000, 1'b0, 32'h0});
    step(1);
    b_valid = 0;
    step(5);

    // Reset on the accept edge: ballot is dropped entirely
    b_valid = 1; b_sel = 2; b_bit = 1; rst = 1;
    step(1);
    rst = 0; b_valid = 0;
    chk("rstaccept_tally", b_tally, 32'h0);
    chk("rstaccept_ready", {31'b0, b_ready}, 32'h1);
    step(1);

    // Bad select on A (N_OUT=3): error pulse, lockout still applied
    a_valid = 1; a_sel = 3; a_bit = 1;
    qa.push_back('{cyc + 1, 4'b0000, 4'b0000, 1'b1, 32'h0});
    step(1);
    a_valid = 0;
    chk("badsel_emit_ready", {30'b0, a_ready, a_busy}, 32'h1);
    step(1);
    chk("badsel_hold_ready", {31'b0, a_ready}, 32'h0);
    step(1);
    chk("badsel_idle_ready", {31'b0, a_ready}, 32'h1);
    chk("badsel_tally", {26'b0, a_tally}, 32'h0);

    // Saturation on A lane 0 with 2-bit tally
    for (int j = 1; j <= 5; j++) begin
      a_valid = 1; a_sel = 0; a_bit = 1;
      qa.push_back('{cyc + 1, 4'b0001, 4'b0001, 1'b0, (j > 3) ? 32'd3 : 32'(j)});
      step(1);
      a_valid = 0;
      step(2);
    end
    a_valid = 1; a_sel = 0; a_bit = 1; a_clr = 1;
    qa.push_back('{cyc + 1, 4'b0001, 4'b0001, 1'b0, 32'h0});
    step(1);
    a_valid = 0; a_clr = 0;
    step(2);
    chk("clr_wins", {26'b0, a_tally}, 32'h0);

    // LOCKOUT=0 back-to-back on C, in_valid held high throughout
    tc = '0;
    c_valid = 1; c_bit = 1;
    for (int s = 0; s < 4; s++) begin
      c_sel = 2'(s);
      oh = 4'b0001 << s;
      tc = tc | (32'h1 << (8 * s));
      qc.push_back('{cyc + 1, oh, oh, 1'b0, tc});
      step(1);
      chk("b2b_emit_ready", {31'b0, c_ready}, 32'h0);
      step(1);
      chk("b2b_idle_ready", {31'b0, c_ready}, 32'h1);
    end
    c_valid = 0;
    step(3);
    chk("b2b_tally", c_tally, 32'h0101_0101);

    chk("qa_drained", 32'(qa.size()), 32'h0);
    chk("qb_drained", 32'(qb.size()), 32'h0);
    chk("qc_drained", 32'(qc.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
